// File: rtl/instr_fetch_if.sv
// instr_fetch_if: control, memory handshake and status bundle of the instruction fetch sequencer.
// Latency: none, wires only.
// Backpressure: mem_req is held until mem_ack; start is only honoured while the sequencer is idle.
interface instr_fetch_if #(
    parameter int WIDTH = 8
);
    // controller / memory side inputs to the sequencer
    logic             start;
    logic             flush;
    logic             mem_ack;
    // sequencer outputs
    logic             mem_req;
    logic [1:0]       adrend;
    logic [3:0]       irwrite;
    logic             busy;
    logic             fetch_done;
    logic             pc_inc;
    logic [WIDTH-1:0] instr_count;
    logic             fetch_err;

    // master: the controller and memory that drive the sequencer
    modport master (
        output start, flush, mem_ack,
        input  mem_req, adrend, irwrite, busy, fetch_done, pc_inc, instr_count, fetch_err
    );

    // slave: the fetch sequencer itself
    modport slave (
        input  start, flush, mem_ack,
        output mem_req, adrend, irwrite, busy, fetch_done, pc_inc, instr_count, fetch_err
    );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: byte-serial fetch of a 32-bit instruction from 8-bit memory over req/ack (INSTR_FETCH_TIMEOUT_EN adds a per-byte timeout).
// Latency: fetch_done/pc_inc 5 cycles after the start edge with zero-wait memory, plus one cycle per wait cycle.
// Backpressure: mem_req stays high until mem_ack; start only accepted in IDLE; flush aborts a fetch without a partial write.
module instr_fetch #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         reset,
    instr_fetch_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // The wait counter is 8 bits wide, so the timeout must fit in it.
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("instr_fetch: TIMEOUT must be within 1..255");
    end

    state_e           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;

    logic             mem_req;
    logic [1:0]       adrend;
    logic [3:0]       irwrite;
    logic             busy;
    logic             fetch_done;
    logic             pc_inc;
    logic             fetch_err;

`ifdef INSTR_FETCH_TIMEOUT_EN
    // Counter value seen in the last permitted wait cycle of a byte.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
    logic [7:0] wait_q, wait_d;
`endif

    // Next-state, byte index, counter and output decode.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        mem_req    = 1'b0;
        adrend     = 2'd0;
        irwrite    = 4'b0000;
        busy       = 1'b0;
        fetch_done = 1'b0;
        pc_inc     = 1'b0;
        fetch_err  = 1'b0;
`ifdef INSTR_FETCH_TIMEOUT_EN
        wait_d     = wait_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // flush outranks start, so a simultaneous pair is dropped
                if (bus.start && !bus.flush) begin
                    state_d = ST_REQ;
                    idx_d   = 2'd0;
`ifdef INSTR_FETCH_TIMEOUT_EN
                    wait_d  = 8'd0;
`endif
                end
            end

            ST_REQ: begin
                mem_req = 1'b1;
                busy    = 1'b1;
                adrend  = idx_q;
                if (bus.flush) begin
                    // abort: no strobe this cycle, bytes already written stay in the IR
                    state_d = ST_IDLE;
                    idx_d   = 2'd0;
`ifdef INSTR_FETCH_TIMEOUT_EN
                    wait_d  = 8'd0;
`endif
                end else if (bus.mem_ack) begin
                    // memdata is valid now; the datapath IR byte captures on this edge
                    irwrite = 4'b0001 << idx_q;
`ifdef INSTR_FETCH_TIMEOUT_EN
                    wait_d  = 8'd0;
`endif
                    if (idx_q == 2'd3) begin
                        state_d = ST_DONE;
                        idx_d   = 2'd0;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                    end
                end else begin
`ifdef INSTR_FETCH_TIMEOUT_EN
                    // an ack in the expiry cycle takes the branch above, so it wins
                    if (wait_q == WAIT_LAST) begin
                        fetch_err = 1'b1;
                        state_d   = ST_IDLE;
                        idx_d     = 2'd0;
                        wait_d    = 8'd0;
                    end else begin
                        wait_d    = wait_q + 8'd1;
                    end
`endif
                end
            end

            ST_DONE: begin
                // already committed: a flush here does not cancel the pulse or the count
                busy       = 1'b1;
                fetch_done = 1'b1;
                pc_inc     = 1'b1;
                cnt_d      = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
                state_d    = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                idx_d   = 2'd0;
            end
        endcase
    end

    // State, byte index and completed-fetch counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef INSTR_FETCH_TIMEOUT_EN
    // Per-byte wait counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_q <= 8'd0;
        end else begin
            wait_q <= wait_d;
        end
    end
`endif

    assign bus.mem_req     = mem_req;
    assign bus.adrend      = adrend;
    assign bus.irwrite     = irwrite;
    assign bus.busy        = busy;
    assign bus.fetch_done  = fetch_done;
    assign bus.pc_inc      = pc_inc;
    assign bus.instr_count = cnt_q;
    assign bus.fetch_err   = fetch_err;

    // Byte strobes are at most one-hot and only ever fire while requesting.
    a_irwrite_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(irwrite));
    a_irwrite_in_req: assert property (@(posedge clk) disable iff (!reset)
                                       (state_q != ST_REQ) |-> (irwrite == 4'b0000));

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized fetch transactions; expectations are queued at stimulus time and popped by a monitor.
// Latency: expected event cycles follow from 5 + total wait cycles per fetch.
// Backpressure: the bench plays memory, inserting wait cycles by holding mem_ack low.
module tb_instr_fetch;
    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    instr_fetch_if #(.WIDTH(WIDTH)) bus ();

    instr_fetch #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // datapath instruction register fed by the byte strobes
    logic [7:0]  memdata = 8'h00;
    logic [31:0] ir      = 32'h0;
    int          cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (bus.irwrite[k]) ir[8*k +: 8] <= memdata;
        end
    end

    typedef struct {
        int cyc;
        int idx;
    } wr_t;

    typedef struct {
        int               cyc;
        logic [31:0]      word;
        logic [WIDTH-1:0] cnt;
    } done_t;

    wr_t   exp_wr_q[$];
    done_t exp_done_q[$];
    int    exp_err_q[$];

    logic       exp_req  = 1'b0;
    logic       exp_busy = 1'b0;
    logic [1:0] exp_adr  = 2'd0;
    int         model_cnt = 0;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compares every cycle against the queued expectations.
    logic [3:0] e_wr;
    logic       e_done;
    logic       e_err;
    wr_t        mw;
    done_t      md;
    always @(negedge clk) begin
        if (reset) begin
            check("mem_req", 64'(bus.mem_req), 64'(exp_req));
            check("busy", 64'(bus.busy), 64'(exp_busy));
            if (exp_req) check("adrend", 64'(bus.adrend), 64'(exp_adr));

            e_wr = 4'b0000;
            if (exp_wr_q.size() > 0 && exp_wr_q[0].cyc == cyc) begin
                mw   = exp_wr_q.pop_front();
                e_wr = 4'b0001 << mw.idx;
            end
            check("irwrite", 64'(bus.irwrite), 64'(e_wr));

            e_done = 1'b0;
            if (exp_done_q.size() > 0 && exp_done_q[0].cyc == cyc) begin
                md     = exp_done_q.pop_front();
                e_done = 1'b1;
                check("instr_word", 64'(ir), 64'(md.word));
                check("instr_count", 64'(bus.instr_count), 64'(md.cnt));
            end
            check("fetch_done", 64'(bus.fetch_done), 64'(e_done));
            check("pc_inc", 64'(bus.pc_inc), 64'(e_done));

            e_err = 1'b0;
            if (exp_err_q.size() > 0 && exp_err_q[0] == cyc) begin
                void'(exp_err_q.pop_front());
                e_err = 1'b1;
            end
            check("fetch_err", 64'(bus.fetch_err), 64'(e_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input int k);
        wr_t e;
        e.cyc = cyc;
        e.idx = k;
        exp_wr_q.push_back(e);
    endtask

    // One idle cycle; start is only raised together with flush so it must be ignored.
    task automatic idle_cycle(input logic st);
        bus.start   = st;
        bus.flush   = st ? 1'b1 : 1'($urandom);
        bus.mem_ack = 1'($urandom);
        memdata     = 8'($urandom);
        exp_req     = 1'b0;
        exp_busy    = 1'b0;
        tick();
    endtask

    // A fetch: waits[k] silent cycles before byte k; flush_at<4 aborts on that byte's ack cycle.
    task automatic do_fetch(input logic [31:0] word, input logic [3:0][7:0] waits,
                            input int flush_at, input logic done_start);
        done_t d;
        bus.start   = 1'b1;
        bus.flush   = 1'b0;
        bus.mem_ack = 1'($urandom);
        exp_req     = 1'b0;
        exp_busy    = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            for (int w = 0; w < int'(waits[k]); w++) begin
                bus.start   = 1'($urandom);
                bus.flush   = 1'b0;
                bus.mem_ack = 1'b0;
                memdata     = 8'($urandom);
                exp_req     = 1'b1;
                exp_busy    = 1'b1;
                exp_adr     = 2'(k);
                tick();
            end
            bus.start   = 1'($urandom);
            bus.mem_ack = 1'b1;
            memdata     = word[8*k +: 8];
            exp_req     = 1'b1;
            exp_busy    = 1'b1;
            exp_adr     = 2'(k);
            if (k == flush_at) begin
                bus.flush = 1'b1;
                tick();
                bus.flush = 1'b0;
                return;
            end
            bus.flush = 1'b0;
            push_wr(k);
            tick();
        end
        bus.start   = done_start;
        bus.flush   = 1'($urandom);
        bus.mem_ack = 1'($urandom);
        exp_req     = 1'b0;
        exp_busy    = 1'b1;
        d.cyc  = cyc;
        d.word = word;
        d.cnt  = WIDTH'(model_cnt);
        exp_done_q.push_back(d);
        model_cnt++;
        tick();
        bus.start = 1'b0;
        bus.flush = 1'b0;
    endtask

`ifdef INSTR_FETCH_TIMEOUT_EN
    // Acknowledge tidx bytes, then stay silent until the timeout fires.
    task automatic do_timeout(input int tidx);
        bus.start   = 1'b1;
        bus.flush   = 1'b0;
        bus.mem_ack = 1'b0;
        exp_req     = 1'b0;
        exp_busy    = 1'b0;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < tidx; k++) begin
            bus.mem_ack = 1'b1;
            memdata     = 8'($urandom);
            exp_req     = 1'b1;
            exp_busy    = 1'b1;
            exp_adr     = 2'(k);
            push_wr(k);
            tick();
        end
        for (int w = 0; w < TIMEOUT; w++) begin
            bus.mem_ack = 1'b0;
            exp_req     = 1'b1;
            exp_busy    = 1'b1;
            exp_adr     = 2'(tidx);
            if (w == TIMEOUT - 1) exp_err_q.push_back(cyc);
            tick();
        end
    endtask
`endif

    logic [3:0][7:0] rw;
    int              fa;
    int              gap;

    initial begin
        bus.start   = 1'b0;
        bus.flush   = 1'b0;
        bus.mem_ack = 1'b0;

        // reset state
        #2 reset = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        check("rst_mem_req", 64'(bus.mem_req), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_irwrite", 64'(bus.irwrite), 64'd0);
        check("rst_adrend", 64'(bus.adrend), 64'd0);
        check("rst_fetch_done", 64'(bus.fetch_done), 64'd0);
        check("rst_pc_inc", 64'(bus.pc_inc), 64'd0);
        check("rst_instr_count", 64'(bus.instr_count), 64'd0);
        check("rst_fetch_err", 64'(bus.fetch_err), 64'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        // zero-wait fetch
        idle_cycle(1'b0);
        do_fetch(32'h44332211, '0, 4, 1'b0);
        check("first_count", 64'(bus.instr_count), 64'd1);
        check("first_ir", 64'(ir), 64'h44332211);

        // three wait cycles before each byte
        idle_cycle(1'b1);
        do_fetch(32'hCAFEF00D, {8'd3, 8'd3, 8'd3, 8'd3}, 4, 1'b0);

        // flush together with the ack of byte 2, then a clean refetch with start held through DONE
        do_fetch(32'hDEADBEEF, '0, 2, 1'b0);
        check("count_after_flush", 64'(bus.instr_count), 64'(WIDTH'(model_cnt)));
        do_fetch(32'h0BADC0DE, '0, 4, 1'b1);
        do_fetch(32'h12345678, {8'd0, 8'd1, 8'd2, 8'd0}, 4, 1'b0);

`ifdef INSTR_FETCH_TIMEOUT_EN
        do_timeout(0);
        do_timeout(2);
        check("count_after_timeout", 64'(bus.instr_count), 64'(WIDTH'(model_cnt)));
        do_fetch(32'h5A5AA5A5, {8'd0, 8'd0, 8'd0, 8'(TIMEOUT - 1)}, 4, 1'b0);
`else
        do_fetch(32'h87654321, {8'd1, 8'd0, 8'd0, 8'd20}, 4, 1'b0);
`endif

        // randomized traffic
        for (int n = 0; n < 60; n++) begin
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) idle_cycle(1'($urandom));
            for (int k = 0; k < 4; k++) rw[k] = 8'($urandom_range(0, 3));
            fa = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : 4;
            do_fetch($urandom, rw, fa, 1'($urandom));
        end

        // asynchronous reset between edges while byte 1 is being acknowledged
        idle_cycle(1'b0);
        bus.start   = 1'b1;
        bus.flush   = 1'b0;
        bus.mem_ack = 1'b0;
        exp_req     = 1'b0;
        exp_busy    = 1'b0;
        tick();
        bus.start   = 1'b0;
        bus.mem_ack = 1'b1;
        memdata     = 8'hA5;
        exp_req     = 1'b1;
        exp_busy    = 1'b1;
        exp_adr     = 2'd0;
        push_wr(0);
        tick();
        memdata = 8'h5A;
        #2;
        check("pre_reset_irwrite", 64'(bus.irwrite), 64'h2);
        check("pre_reset_mem_req", 64'(bus.mem_req), 64'd1);
        reset = 1'b0;
        #1;
        check("async_mem_req", 64'(bus.mem_req), 64'd0);
        check("async_busy", 64'(bus.busy), 64'd0);
        check("async_irwrite", 64'(bus.irwrite), 64'd0);
        check("async_instr_count", 64'(bus.instr_count), 64'd0);
        exp_wr_q.delete();
        exp_done_q.delete();
        exp_err_q.delete();
        model_cnt   = 0;
        exp_req     = 1'b0;
        exp_busy    = 1'b0;
        bus.mem_ack = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;

        // 256 back-to-back fetches wrap the counter
        for (int n = 0; n < 256; n++) do_fetch($urandom, '0, 4, 1'($urandom));
        check("wrap_count", 64'(bus.instr_count), 64'(WIDTH'(model_cnt)));

        idle_cycle(1'b0);
        idle_cycle(1'b1);
        idle_cycle(1'b0);
        check("wr_queue_drained", 64'(exp_wr_q.size()), 64'd0);
        check("done_queue_drained", 64'(exp_done_q.size()), 64'd0);
        check("err_queue_drained", 64'(exp_err_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
